// File: rtl/char_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_link_pkg
// Description : Shared types and constants for the half-duplex character
//               link controller (state encoding, widths, line idle level).
// Revision    : 1.0 - initial release
// ============================================================================
package char_link_pkg;

    localparam int   c_DATA_W     = 8;
    localparam int   c_BIT_IDX_W  = 3;
    localparam logic c_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_START = 3'd1,
        ST_TX_DATA  = 3'd2,
        ST_TX_STOP  = 3'd3,
        ST_RX_START = 3'd4,
        ST_RX_DATA  = 3'd5,
        ST_RX_STOP  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/char_link_baud.sv
`default_nettype none
// ============================================================================
// Module      : char_link_baud
// Description : Loadable bit-period down-counter. Emits a one-cycle tick at
//               terminal count and auto-reloads a full period after it.
//               A load (full or half period) restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module char_link_baud
    import char_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_load_half,
    output logic o_tick
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [c_CNT_W-1:0] r_count;

    // Count down to zero, restart on load or after each terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= c_FULL;
        end else if (i_load) begin
            r_count <= i_load_half ? c_HALF : c_FULL;
        end else if (r_count == '0) begin
            r_count <= c_FULL;
        end else begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/char_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : char_link_ctrl
// Description : Half-duplex 8N1 serial character link controller. Arbitrates
//               one shared line between PIO transmit requests and incoming
//               frames (receive wins ties) and owns the line direction.
// Revision    : 1.0 - initial release
// ============================================================================
module char_link_ctrl
    import char_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_W       = c_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_req,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              frame_err,
    input  logic              serial_in,
    output logic              serial_out,
    output logic              link_dir
);

    localparam logic [c_BIT_IDX_W-1:0] c_LAST_BIT = c_BIT_IDX_W'(DATA_W - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rx_meta;
    logic                    r_rx_sync;
    logic                    r_rx_prev;
    logic [c_BIT_IDX_W-1:0]  r_bit_idx;
    logic [c_BIT_IDX_W-1:0]  w_bit_idx_nxt;
    logic [DATA_W-1:0]       r_tx_shift;
    logic [DATA_W-1:0]       r_rx_shift;
    logic                    r_tx_armed;
    logic                    r_tx_done;
    logic                    r_serial_out;
    logic                    r_link_dir;
    logic [DATA_W-1:0]       r_rx_data;
    logic                    r_rx_valid;
    logic                    r_rx_overrun;
    logic                    r_frame_err;
    logic                    w_serial_nxt;
    logic                    w_start_edge;
    logic                    w_tick;
    logic                    w_baud_load;
    logic                    w_baud_half;
    logic                    w_accept;
    logic                    w_bit_step;
    logic                    w_rx_shift_en;
    logic                    w_stop_good;
    logic                    w_stop_bad;

    char_link_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_baud_load),
        .i_load_half (w_baud_half),
        .o_tick      (w_tick)
    );

    assign w_start_edge = r_rx_prev & ~r_rx_sync;

    // Two-stage synchronizer for the asynchronous line plus one history stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= c_IDLE_LEVEL;
            r_rx_sync <= c_IDLE_LEVEL;
            r_rx_prev <= c_IDLE_LEVEL;
        end else begin
            r_rx_meta <= serial_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Next-state and control strobes; receive start beats a transmit request
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_load   = 1'b0;
        w_baud_half   = 1'b0;
        w_accept      = 1'b0;
        w_bit_step    = 1'b0;
        w_rx_shift_en = 1'b0;
        w_stop_good   = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = ST_RX_START;
                    w_baud_load = 1'b1;
                    w_baud_half = 1'b1;
                end else if (tx_req && r_tx_armed) begin
                    w_state_nxt = ST_TX_START;
                    w_baud_load = 1'b1;
                    w_accept    = 1'b1;
                end
            end
            ST_TX_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_TX_DATA;
                    w_baud_load = 1'b1;
                end
            end
            ST_TX_DATA: begin
                if (w_tick) begin
                    w_bit_step = 1'b1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = ST_TX_STOP;
                        w_baud_load = 1'b1;
                    end
                end
            end
            ST_TX_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_baud_load = 1'b1;
                end
            end
            ST_RX_START: begin
                if (w_tick) begin
                    w_baud_load = 1'b1;
                    w_state_nxt = r_rx_sync ? ST_IDLE : ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (w_tick) begin
                    w_rx_shift_en = 1'b1;
                    w_bit_step    = 1'b1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = ST_RX_STOP;
                        w_baud_load = 1'b1;
                    end
                end
            end
            ST_RX_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_baud_load = 1'b1;
                    w_stop_good = r_rx_sync;
                    w_stop_bad  = ~r_rx_sync;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_load = 1'b1;
            end
        endcase
    end

    // Line level for the coming cycle, registered so the pin never glitches
    always_comb begin
        w_bit_idx_nxt = w_bit_step ? (r_bit_idx + c_BIT_IDX_W'(1)) : r_bit_idx;
        w_serial_nxt  = c_IDLE_LEVEL;
        case (w_state_nxt)
            ST_TX_START: w_serial_nxt = 1'b0;
            ST_TX_DATA:  w_serial_nxt = r_tx_shift[w_bit_idx_nxt];
            default:     w_serial_nxt = c_IDLE_LEVEL;
        endcase
    end

    // State register, bit sequencing, transmit arming and line drivers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_tx_armed   <= 1'b1;
            r_tx_done    <= 1'b0;
            r_serial_out <= c_IDLE_LEVEL;
            r_link_dir   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_serial_out <= w_serial_nxt;
            r_link_dir   <= (w_state_nxt == ST_TX_START) || (w_state_nxt == ST_TX_DATA) ||
                            (w_state_nxt == ST_TX_STOP);
            r_tx_done    <= (r_state == ST_TX_STOP) && w_tick;
            if (w_accept) begin
                r_tx_shift <= tx_data;
            end
            if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
            end
            if (w_accept) begin
                r_tx_armed <= 1'b0;
            end else if (!tx_req) begin
                r_tx_armed <= 1'b1;
            end
        end
    end

    // Receive result, pending/overrun flags and framing error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            if (w_stop_good) begin
                r_rx_data    <= r_rx_shift;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= r_rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end
        end
    end

    assign serial_out = r_serial_out;
    assign link_dir   = r_link_dir;
    assign tx_busy    = r_link_dir;
    assign tx_done    = r_tx_done;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_rx_overrun;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: doc/char_link_ctrl.md
Name: char_link_ctrl

Overview:
- Half-duplex serial character link controller between the Nios PIO character interface and a single shared serial line.
- Arbitrates the line between outgoing transmit requests and incoming frames.
- Sequences 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Owns the direction control, so the send and receive paths never drive the line at the same time.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600 baud); minimum 4.
- DATA_W, 8, character width in bits.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- tx_req  in  1  transmit request from PIO, level; a frame is accepted on a low-to-high arming (see Behaviour).
- tx_data  in  DATA_W  character to send; sampled at acceptance.
- tx_busy  out  1  high from acceptance until the end of the stop bit.
- tx_done  out  1  one-cycle pulse when the stop bit completes.
- rx_data  out  DATA_W  last received character.
- rx_valid  out  1  received character pending; held until rx_ack.
- rx_ack  in  1  PIO acknowledge; clears rx_valid and rx_overrun.
- rx_overrun  out  1  sticky: a frame completed while rx_valid was high.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- serial_in  in  1  line input, asynchronous; idle high.
- serial_out  out  1  line output; idle high.
- link_dir  out  1  1 = controller drives the line (TX), 0 = receive.

Behaviour:
- Reset values:
  - serial_out=1, link_dir=0.
  - tx_busy=0, tx_done=0.
  - rx_data=0, rx_valid=0, rx_overrun=0, frame_err=0.
  - state=IDLE, tx_armed=1.
- Reset mid-frame aborts immediately. serial_out returns to 1 asynchronously and the partial character is discarded.
- serial_in passes through a 2-FF synchronizer. Start-bit detection uses a falling edge on the synchronized value, giving 2 cycles of input latency.
- Arming:
  - tx_armed clears on acceptance.
  - It sets again in any cycle tx_req is sampled low.
  - A held-high tx_req therefore sends exactly one frame.
- States: IDLE, TX_START, TX_DATA, TX_STOP, RX_START, RX_DATA, RX_STOP.
- IDLE:
  - Start edge detected → RX_START. Receive has priority, including when tx_req is armed in the same cycle.
  - Otherwise, tx_req&tx_armed → latch tx_data, set tx_busy and link_dir, go to TX_START.
  - A blocked request stays pending and is accepted in the first IDLE cycle after the receive completes.
- TX timing:
  - serial_out=0 in the cycle after acceptance, for CLKS_PER_BIT cycles.
  - Then 8 data bits, LSB first, each CLKS_PER_BIT cycles.
  - Then a stop bit of 1 for CLKS_PER_BIT cycles.
  - On the last stop cycle's edge: return to IDLE, link_dir=0, tx_busy=0, tx_done=1 for one cycle.
  - Accept-to-tx_done = 10*CLKS_PER_BIT+1 cycles.
- RX_START:
  - Wait CLKS_PER_BIT/2 cycles, then resample.
  - High → glitch, back to IDLE with no outputs changed.
  - Low → RX_DATA.
- RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first; 8 samples.
- RX_STOP, sample taken one bit time later:
  - 1 → rx_data updated, rx_valid=1.
  - If rx_valid was already 1 and rx_ack is not asserted that cycle: rx_overrun=1 and rx_data is overwritten with the new character.
  - 0 → frame_err pulse, rx_data and rx_valid unchanged.
  - Either case → IDLE.
- rx_ack in the same cycle as a new character: the ack applies to the old character. After that cycle rx_valid=1 with the new data and rx_overrun=0.
- The bit counter wraps 7→0 only on state exit. The baud counter reloads on every state entry.

Decomposition:
- Shared package char_link_pkg:
  - state enum.
  - DATA_W default.
  - bit-index width constant (3).
  - IDLE_LEVEL=1.
- Sub-module char_link_baud:
  - Loadable down-counter of CLKS_PER_BIT, with a half-period load option.
  - Emits a one-cycle tick at terminal count.
  - Reloaded by the FSM on state entry.

Test Plan (CLKS_PER_BIT=4):
1. Reset, tx_req=1 with tx_data=0x41:
   - serial_out is 0,1,0,0,0,0,0,1,0,1, each held 4 cycles.
   - tx_done pulses 41 cycles after acceptance.
   - link_dir=1 throughout the frame.
   - Holding tx_req high afterwards produces no second frame.
2. Drive a valid 0x5A frame on serial_in:
   - rx_data=0x5A, rx_valid=1 until the rx_ack cycle, then 0.
   - frame_err stays 0.
3. Start bit on serial_in in the same cycle as an armed tx_req=1, tx_data=0x33:
   - 0xC3 is received first, with link_dir=0.
   - 0x33 transmission then begins in the following IDLE cycle.
4. Two frames (0x11 then 0x22) with no rx_ack: rx_overrun=1, rx_data=0x22. An rx_ack clears both flags.
5. 1-cycle low glitch on serial_in → no rx_valid. Full frame with stop bit=0 → frame_err pulse, rx_valid stays 0.
6. Assert reset at the 5th data bit of a TX frame:
   - serial_out=1 and link_dir=0 immediately.
   - After release, a new tx_req=1 with 0x55 sends a complete, correct frame.
